// File: rtl/conv_stream_pkg.sv
// Shared definitions for the convolution output stream stage.
// Buffered entries are packed as {sof, eol, data}, with sof in the MSB.
package conv_stream_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef struct packed {
    logic                      sof;
    logic                      eol;
    logic [DEFAULT_DATA_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/stream_fifo.sv
// Generic show-ahead synchronous FIFO.
// The head entry is always visible on o_dout while o_empty is low.
// Pointers carry one extra wrap bit. Full and empty are decoded from that bit.
// A push to a full FIFO is accepted only when a pop happens in the same cycle.
// o_almost_full is registered. It reflects the occupancy after this cycle's update.
module stream_fifo
  import conv_stream_pkg::*;
#(
  parameter int WIDTH     = ENTRY_W,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_af;
  logic [AW:0]      w_count;
  logic [AW:0]      w_count_nxt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_count_nxt = w_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);

  assign o_dout        = r_mem[r_rd_ptr[AW-1:0]];
  assign o_almost_full = r_af;

  // Storage array: written on accepted pushes, never reset
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  // Pointer and almost-full registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_af     <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_af <= (w_count_nxt >= (AW+1)'(DEPTH - AF_MARGIN));
    end
  end

endmodule

// File: rtl/conv_out_stream.sv
// Output stage behind the convolution pipeline.
// It buffers the pixel stream in a show-ahead FIFO and emits it as an AXI4-Stream master.
// tuser marks the first pixel of a frame.
// tlast marks the end of each line by default.
// With CONV_OUT_TLAST_FRAME_EN defined, tlast marks only the end of the frame.
// The input has no backpressure. A pixel arriving at a full FIFO is dropped
// and recorded in the sticky o_overflow flag.
//
// AXIS handshake: a beat transfers when m_axis_tvalid && m_axis_tready.
// tvalid never depends on tready. Once tvalid is high, tdata, tlast and tuser
// stay stable until that transfer.
module conv_out_stream
  import conv_stream_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH  = 16,
  parameter int AF_MARGIN   = 4,
  parameter int LINE_PIXELS = 510,
  parameter int FRAME_LINES = 510
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              o_almost_full,
  output logic              o_overflow,
  input  logic              i_clear_ovf
);

  localparam int EW = DATA_W + 2;
  localparam int CW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  logic [CW-1:0] r_col;
  logic [LW-1:0] r_line;
  logic          r_ovf;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_sof;
  logic          w_eol;
  logic          w_col_last;
  logic          w_line_last;
  logic [EW-1:0] w_din;
  logic [EW-1:0] w_dout;

  assign w_col_last  = (r_col == CW'(LINE_PIXELS - 1));
  assign w_line_last = (r_line == LW'(FRAME_LINES - 1));

  assign w_sof = (r_col == '0) && (r_line == '0);
`ifdef CONV_OUT_TLAST_FRAME_EN
  assign w_eol = w_col_last && w_line_last;
`else
  assign w_eol = w_col_last;
`endif

  assign w_din  = {w_sof, w_eol, i_data};
  assign w_pop  = !w_empty && m_axis_tready;
  assign w_push = i_data_valid && (!w_full || w_pop);
  assign w_drop = i_data_valid && w_full && !w_pop;

  assign m_axis_tvalid = !w_empty;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = w_dout;
  assign o_overflow = r_ovf;

  // Frame geometry counters advance on every input pixel, dropped or not
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (i_data_valid) begin
      if (w_col_last) begin
        r_col  <= '0;
        r_line <= w_line_last ? '0 : r_line + LW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Sticky overflow flag; a drop in the same cycle overrides a clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         r_ovf <= 1'b0;
    else if (w_drop)      r_ovf <= 1'b1;
    else if (i_clear_ovf) r_ovf <= 1'b0;
  end

  stream_fifo #(
    .WIDTH     (EW),
    .DEPTH     (FIFO_DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_fifo (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_din         (w_din),
    .o_dout        (w_dout),
    .o_empty       (w_empty),
    .o_full        (w_full),
    .o_almost_full (o_almost_full)
  );

endmodule
